// File: rtl/stack_sequencer_if.sv
// Bus between the CPU-side logic and the stack sequencer: pipeline push/pop,
// burst save/restore handshake, register-file port, stack port and status.
interface stack_sequencer_if #(
    parameter int CW = 8
);
    logic          cpu_push;
    logic          cpu_pop;
    logic [31:0]   cpu_d;
    logic          save_req;
    logic          restore_req;
    logic          ack;
    logic          busy;
    logic          done;
    logic [3:0]    rf_raddr;
    logic [31:0]   rf_rdata;
    logic          rf_we;
    logic [3:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic          stk_push;
    logic          stk_pop;
    logic [31:0]   stk_d;
    logic [31:0]   stk_q;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;
    logic          err_clr;

    // CPU / register file / stack side
    modport master (
        output cpu_push, cpu_pop, cpu_d, save_req, restore_req,
        output rf_rdata, stk_q, err_clr,
        input  ack, busy, done, rf_raddr, rf_we, rf_waddr, rf_wdata,
        input  stk_push, stk_pop, stk_d, count, overflow, underflow
    );

    // Sequencer side
    modport slave (
        input  cpu_push, cpu_pop, cpu_d, save_req, restore_req,
        input  rf_rdata, stk_q, err_clr,
        output ack, busy, done, rf_raddr, rf_we, rf_waddr, rf_wdata,
        output stk_push, stk_pop, stk_d, count, overflow, underflow
    );
endinterface

// File: rtl/stack_sequencer.sv
// Stack sequencer: forwards single pipeline push/pop to the hardware stack,
// runs burst save (r1..rNREGS -> stack) and burst restore (stack -> rNREGS..r1),
// tracks occupancy and raises sticky overflow/underflow flags.
module stack_sequencer #(
    parameter int NREGS = 15,
    parameter int DEPTH = 128,
    parameter int CW    = 8
) (
    input logic              clk,
    input logic              reset,
    stack_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DRAIN} state_t;

    localparam logic [CW-1:0] FULL       = CW'(DEPTH);
    localparam logic [CW-1:0] SAVE_LIMIT = CW'(DEPTH - NREGS);
    localparam logic [CW-1:0] NR         = CW'(NREGS);
    localparam logic [CW-1:0] NR_LAST    = CW'(NREGS - 1);
    localparam logic [3:0]    NR4        = 4'(NREGS);

    state_t        state, state_nxt;
    logic [CW-1:0] step, step_nxt;
    logic [CW-1:0] count_q;
    logic          wb_valid, wb_valid_nxt;
    logic [3:0]    wb_addr, wb_addr_nxt;
    logic          done_q, done_nxt;
    logic          ovf_q, unf_q, ovf_set, unf_set;
    logic          push_go, pop_go, ack_c;
    logic [31:0]   stk_d_c;
    logic [3:0]    raddr_c;

    // Next-state, stack strobes, burst accept and error detection
    always_comb begin
        state_nxt    = state;
        step_nxt     = step;
        wb_valid_nxt = 1'b0;
        wb_addr_nxt  = '0;
        done_nxt     = 1'b0;
        ovf_set      = 1'b0;
        unf_set      = 1'b0;
        push_go      = 1'b0;
        pop_go       = 1'b0;
        ack_c        = 1'b0;
        stk_d_c      = '0;
        raddr_c      = '0;
        unique case (state)
            IDLE: begin
                stk_d_c = bus.cpu_d;
                if (bus.cpu_push) begin
                    if (count_q == FULL) ovf_set = 1'b1;
                    else                 push_go = 1'b1;
                end else if (bus.cpu_pop) begin
                    if (count_q == '0) unf_set = 1'b1;
                    else               pop_go  = 1'b1;
                end else if (bus.save_req) begin
                    ack_c = 1'b1;
                    if (count_q <= SAVE_LIMIT) begin
                        state_nxt = SAVE;
                        step_nxt  = CW'(1);
                    end else begin
                        ovf_set = 1'b1;
                    end
                end else if (bus.restore_req) begin
                    ack_c = 1'b1;
                    if (count_q >= NR) begin
                        state_nxt = RESTORE;
                        step_nxt  = '0;
                    end else begin
                        unf_set = 1'b1;
                    end
                end
            end
            SAVE: begin
                raddr_c = step[3:0];
                stk_d_c = bus.rf_rdata;
                push_go = 1'b1;
                if (step == NR) begin
                    state_nxt = IDLE;
                    step_nxt  = '0;
                    done_nxt  = 1'b1;
                end else begin
                    step_nxt = step + CW'(1);
                end
            end
            RESTORE: begin
                // Popped word arrives next cycle; remember where it goes.
                pop_go       = 1'b1;
                wb_valid_nxt = 1'b1;
                wb_addr_nxt  = NR4 - step[3:0];
                if (step == NR_LAST) begin
                    state_nxt = DRAIN;
                    step_nxt  = '0;
                end else begin
                    step_nxt = step + CW'(1);
                end
            end
            DRAIN: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, step counter, write-back pipeline, occupancy and sticky flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            step     <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            done_q   <= 1'b0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            step     <= step_nxt;
            wb_valid <= wb_valid_nxt;
            wb_addr  <= wb_addr_nxt;
            done_q   <= done_nxt;
            if (push_go)     count_q <= count_q + CW'(1);
            else if (pop_go) count_q <= count_q - CW'(1);
            ovf_q <= ovf_set | (ovf_q & ~bus.err_clr);
            unf_q <= unf_set | (unf_q & ~bus.err_clr);
        end
    end

    // Input-derived outputs are gated so everything reads 0 while reset is held
    assign bus.stk_push  = push_go & ~reset;
    assign bus.stk_pop   = pop_go & ~reset;
    assign bus.stk_d     = reset ? '0 : stk_d_c;
    assign bus.ack       = ack_c & ~reset;
    assign bus.rf_raddr  = reset ? '0 : raddr_c;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.rf_we     = wb_valid;
    assign bus.rf_waddr  = wb_valid ? wb_addr : '0;
    assign bus.rf_wdata  = wb_valid ? bus.stk_q : '0;
    assign bus.count     = count_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: table vectors, hand-written burst sequences and
// randomized traffic checked against a queue-based model of the stack.
module tb_stack_sequencer;
    localparam int NREGS = 15;
    localparam int DEPTH = 128;
    localparam int CW    = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stack_sequencer_if #(.CW(CW)) bus ();
    stack_sequencer #(.NREGS(NREGS), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Hardware stack: push stores, pop presents the top word the next cycle
    logic [31:0] stk_mem [DEPTH];
    logic [7:0]  sp;
    logic [7:0]  sp_top;
    logic [31:0] stk_q_r;
    assign sp_top    = sp - 8'd1;
    assign bus.stk_q = stk_q_r;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sp      <= '0;
            stk_q_r <= '0;
        end else if (bus.stk_push && sp < 8'(DEPTH)) begin
            stk_mem[sp[6:0]] <= bus.stk_d;
            sp <= sp + 8'd1;
        end else if (bus.stk_pop && sp > 8'd0) begin
            stk_q_r <= stk_mem[sp_top[6:0]];
            sp <= sp_top;
        end
    end

    // Register file: combinational read, clocked write, bulk preload
    logic [31:0] rf [16];
    logic        load_now;
    logic [31:0] load_base;
    assign bus.rf_rdata = rf[bus.rf_raddr];
    always @(posedge clk) begin
        if (load_now) begin
            for (int k = 0; k < 16; k++) rf[k] <= load_base + 32'(k);
        end else if (bus.rf_we) begin
            rf[bus.rf_waddr] <= bus.rf_wdata;
        end
    end

    // Reference model
    logic [31:0] mstk [$];
    bit          m_ovf, m_unf;
    logic [31:0] rf_model [16];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit push, input bit pop, input logic [31:0] d,
                         input bit sv, input bit rs, input bit clr);
        bus.cpu_push    = push;
        bus.cpu_pop     = pop;
        bus.cpu_d       = d;
        bus.save_req    = sv;
        bus.restore_req = rs;
        bus.err_clr     = clr;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " ack"},       32'(bus.ack), 0);
        chk({tag, " busy"},      32'(bus.busy), 0);
        chk({tag, " done"},      32'(bus.done), 0);
        chk({tag, " stk_push"},  32'(bus.stk_push), 0);
        chk({tag, " stk_pop"},   32'(bus.stk_pop), 0);
        chk({tag, " stk_d"},     bus.stk_d, 0);
        chk({tag, " rf_we"},     32'(bus.rf_we), 0);
        chk({tag, " rf_raddr"},  32'(bus.rf_raddr), 0);
        chk({tag, " rf_waddr"},  32'(bus.rf_waddr), 0);
        chk({tag, " rf_wdata"},  bus.rf_wdata, 0);
        chk({tag, " count"},     32'(bus.count), 0);
        chk({tag, " overflow"},  32'(bus.overflow), 0);
        chk({tag, " underflow"}, 32'(bus.underflow), 0);
    endtask

    task automatic load_regs(input logic [31:0] base);
        @(negedge clk);
        drive(0, 0, '0, 0, 0, 0);
        load_now  = 1'b1;
        load_base = base;
        @(posedge clk); #1;
        load_now = 1'b0;
        for (int k = 0; k < 16; k++) rf_model[k] = base + 32'(k);
    endtask

    // One idle-state pipeline cycle checked against the model
    task automatic cpu_cycle(input bit push, input bit pop, input logic [31:0] d, input bit clr);
        int          size;
        bit          e_push, e_pop;
        logic [31:0] popped;
        popped = '0;
        @(negedge clk);
        drive(push, pop, d, 0, 0, clr);
        #1;
        size   = mstk.size();
        e_push = push && size < DEPTH;
        e_pop  = !push && pop && size > 0;
        chk("cpu stk_push", 32'(bus.stk_push), 32'(e_push));
        chk("cpu stk_pop",  32'(bus.stk_pop),  32'(e_pop));
        chk("cpu ack",      32'(bus.ack), 0);
        if (e_push) begin
            chk("cpu stk_d", bus.stk_d, d);
            mstk.push_back(d);
        end
        if (e_pop) popped = mstk.pop_back();
        m_ovf = (push && size == DEPTH) || (m_ovf && !clr);
        m_unf = (!push && pop && size == 0) || (m_unf && !clr);
        @(posedge clk); #1;
        chk("cpu count",     32'(bus.count), 32'(mstk.size()));
        chk("cpu overflow",  32'(bus.overflow), 32'(m_ovf));
        chk("cpu underflow", 32'(bus.underflow), 32'(m_unf));
        if (e_pop) chk("cpu stk_q", bus.stk_q, popped);
    endtask

    // Burst request (optionally preceded by a same-cycle push) and full sequence
    task automatic burst(input bit sv, input bit rs, input bit with_push);
        int          size, len;
        bit          accept;
        logic [31:0] vals [NREGS];
        logic [31:0] d;
        if (with_push) begin
            d = $urandom;
            @(negedge clk);
            drive(1, 0, d, sv, rs, 0);
            #1;
            size = mstk.size();
            chk("defer ack",      32'(bus.ack), 0);
            chk("defer stk_push", 32'(bus.stk_push), 32'(size < DEPTH));
            if (size < DEPTH) mstk.push_back(d);
            else m_ovf = 1'b1;
            @(posedge clk); #1;
            chk("defer count", 32'(bus.count), 32'(mstk.size()));
        end
        @(negedge clk);
        drive(0, 0, '0, sv, rs, 0);
        #1;
        size   = mstk.size();
        accept = sv ? (size <= DEPTH - NREGS) : (size >= NREGS);
        chk("req ack",      32'(bus.ack), 1);
        chk("req busy",     32'(bus.busy), 0);
        chk("req stk_push", 32'(bus.stk_push), 0);
        chk("req stk_pop",  32'(bus.stk_pop), 0);
        if (!accept) begin
            if (sv) m_ovf = 1'b1;
            else    m_unf = 1'b1;
        end
        @(posedge clk); #1;
        chk("req overflow",  32'(bus.overflow), 32'(m_ovf));
        chk("req underflow", 32'(bus.underflow), 32'(m_unf));
        if (!accept) begin
            @(negedge clk);
            drive(0, 0, '0, 0, 0, 0);
            #1;
            chk("reject busy", 32'(bus.busy), 0);
            chk("reject done", 32'(bus.done), 0);
            @(posedge clk); #1;
            chk("reject count", 32'(bus.count), 32'(size));
            return;
        end
        len = sv ? NREGS + 1 : NREGS + 2;
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            if (c < len) drive(bit'($urandom_range(1)), bit'($urandom_range(1)), $urandom, 0, 0, 0);
            else         drive(0, 0, '0, 0, 0, 0);
            #1;
            chk("burst done", 32'(bus.done), 32'(c == len));
            chk("burst busy", 32'(bus.busy), 32'(c < len));
            if (sv) begin
                chk("save stk_pop", 32'(bus.stk_pop), 0);
                chk("save stk_push", 32'(bus.stk_push), 32'(c < len));
                if (c < len) begin
                    chk("save rf_raddr", 32'(bus.rf_raddr), 32'(c));
                    chk("save stk_d", bus.stk_d, rf_model[c]);
                    mstk.push_back(rf_model[c]);
                end
            end else begin
                chk("restore stk_push", 32'(bus.stk_push), 0);
                chk("restore stk_pop", 32'(bus.stk_pop), 32'(c <= NREGS));
                if (c <= NREGS) vals[c-1] = mstk.pop_back();
                chk("restore rf_we", 32'(bus.rf_we), 32'(c >= 2 && c <= NREGS + 1));
                if (c >= 2 && c <= NREGS + 1) begin
                    chk("restore rf_waddr", 32'(bus.rf_waddr), 32'(NREGS - (c - 2)));
                    chk("restore rf_wdata", bus.rf_wdata, vals[c-2]);
                    rf_model[NREGS - (c - 2)] = vals[c-2];
                end
            end
            @(posedge clk); #1;
            chk("burst count",     32'(bus.count), 32'(mstk.size()));
            chk("burst overflow",  32'(bus.overflow), 32'(m_ovf));
            chk("burst underflow", 32'(bus.underflow), 32'(m_unf));
        end
    endtask

    typedef struct {
        bit          push, pop;
        logic [31:0] d;
        bit          clr;
        bit          e_push, e_pop;
        int          e_count;
        bit          e_ovf, e_unf;
        bit          q_chk;
        logic [31:0] e_q;
    } vec_t;

    vec_t vt [14];

    initial begin : main
        vt[0]  = '{1, 0, 32'hA, 0, 1, 0, 1, 0, 0, 0, 32'h0};
        vt[1]  = '{1, 0, 32'hB, 0, 1, 0, 2, 0, 0, 0, 32'h0};
        vt[2]  = '{1, 0, 32'hC, 0, 1, 0, 3, 0, 0, 0, 32'h0};
        vt[3]  = '{0, 1, 32'h0, 0, 0, 1, 2, 0, 0, 1, 32'hC};
        vt[4]  = '{0, 1, 32'h0, 0, 0, 1, 1, 0, 0, 1, 32'hB};
        vt[5]  = '{0, 1, 32'h0, 0, 0, 1, 0, 0, 0, 1, 32'hA};
        vt[6]  = '{1, 1, 32'hD, 0, 1, 0, 1, 0, 0, 0, 32'h0};
        vt[7]  = '{0, 1, 32'h0, 0, 0, 1, 0, 0, 0, 1, 32'hD};
        vt[8]  = '{0, 1, 32'h0, 0, 0, 0, 0, 0, 1, 0, 32'h0};
        vt[9]  = '{0, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 32'h0};
        vt[10] = '{0, 1, 32'h0, 1, 0, 0, 0, 0, 1, 0, 32'h0};
        vt[11] = '{0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 32'h0};
        vt[12] = '{0, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 32'h0};
        vt[13] = '{0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0};

        reset    = 1'b1;
        load_now = 1'b0;
        load_base = '0;
        drive(0, 0, '0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk) reset = 1'b0;
        mstk.delete(); m_ovf = 0; m_unf = 0;

        // Table vectors: LIFO order, push-wins, underflow and err_clr interplay
        load_regs(32'h100);
        foreach (vt[i]) begin
            @(negedge clk);
            drive(vt[i].push, vt[i].pop, vt[i].d, 0, 0, vt[i].clr);
            #1;
            chk("vec stk_push", 32'(bus.stk_push), 32'(vt[i].e_push));
            chk("vec stk_pop",  32'(bus.stk_pop),  32'(vt[i].e_pop));
            @(posedge clk); #1;
            chk("vec count",     32'(bus.count), 32'(vt[i].e_count));
            chk("vec overflow",  32'(bus.overflow), 32'(vt[i].e_ovf));
            chk("vec underflow", 32'(bus.underflow), 32'(vt[i].e_unf));
            if (vt[i].q_chk) chk("vec stk_q", bus.stk_q, vt[i].e_q);
        end

        // Save r1..r15, clobber, restore, registers back to original values
        burst(1, 0, 0);
        chk("after save count", 32'(bus.count), 32'(NREGS));
        load_regs(32'hDEAD_0000);
        burst(0, 1, 0);
        chk("after restore count", 32'(bus.count), 0);
        for (int k = 1; k <= NREGS; k++) chk("restored reg", rf[k], 32'h100 + 32'(k));

        // Fill to 120: save rejected with overflow; then fill to 128 and overflow
        for (int i = 0; i < 120; i++) cpu_cycle(1, 0, $urandom, 0);
        burst(1, 0, 0);
        chk("reject overflow", 32'(bus.overflow), 1);
        cpu_cycle(0, 0, '0, 1);
        for (int i = 0; i < 9; i++) cpu_cycle(1, 0, $urandom, 0);
        chk("full count", 32'(bus.count), 128);
        chk("full overflow", 32'(bus.overflow), 1);
        cpu_cycle(0, 0, '0, 1);

        // Down to 20, simultaneous requests, then request deferred by a push
        for (int i = 0; i < 108; i++) cpu_cycle(0, 1, '0, 0);
        burst(1, 1, 0);
        chk("both -> save count", 32'(bus.count), 35);
        burst(1, 0, 1);
        chk("deferred save count", 32'(bus.count), 51);
        burst(0, 1, 0);

        // Reset in cycle A+5 of a restore
        @(negedge clk);
        drive(0, 0, '0, 0, 1, 0);
        #1 chk("rst-req ack", 32'(bus.ack), 1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            drive(0, 0, '0, 0, 0, 0);
        end
        @(negedge clk);
        drive(1, 1, 32'h5555_AAAA, 1, 1, 0);
        reset = 1'b1;
        #1 check_zero("mid-burst reset");
        @(negedge clk);
        drive(0, 0, '0, 0, 0, 0);
        reset = 1'b0;
        mstk.delete(); m_ovf = 0; m_unf = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("post-reset done", 32'(bus.done), 0);
            chk("post-reset busy", 32'(bus.busy), 0);
            chk("post-reset count", 32'(bus.count), 0);
            @(negedge clk);
        end
        cpu_cycle(1, 0, 32'h1234_0001, 0);
        cpu_cycle(1, 0, 32'h1234_0002, 0);
        cpu_cycle(0, 1, '0, 0);
        cpu_cycle(0, 1, '0, 0);

        // Randomized traffic with occasional bursts
        for (int i = 0; i < 600; i++) begin
            int unsigned r;
            int unsigned sel;
            r = $urandom_range(99);
            if (r < 4) begin
                sel = $urandom_range(2);
                burst(sel != 1, sel != 0, bit'($urandom_range(1)));
            end else begin
                bit p, q, clr;
                p   = ($urandom_range(99) < ((i / 150) % 2 == 0 ? 65 : 30));
                q   = ($urandom_range(99) < 60);
                clr = ($urandom_range(99) < 5);
                cpu_cycle(p, q, $urandom, clr);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
